// File: rtl/avalon_mm_responder.sv
// rtl/avalon_mm_responder.sv - Avalon-MM responder backed by a word memory with programmable wait states.
// Optional statistics counters are enabled by defining RESP_STATS_EN.
module avalon_mm_responder #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] OOR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic            op_wr_q, op_wr_d;
    logic            op_oor_q, op_oor_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     readdata_q, readdata_d;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     offset;
    logic            req_oor;
    logic [AW-1:0]   req_idx;
    logic            enter_ack;
    logic            ack_done;
    logic            abort;
    logic            mem_we;

    // Addresses below the base wrap to large offsets and so decode as out of range.
    assign offset  = address - BASE_ADDR;
    assign req_oor = (offset >= 32'(DEPTH * 4));
    assign req_idx = offset[AW+1:2];

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        op_wr_d    = op_wr_q;
        op_oor_d   = op_oor_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        readdata_d = readdata_q;
        enter_ack  = 1'b0;
        ack_done   = 1'b0;
        abort      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read || write) begin
                    op_wr_d  = write;
                    op_oor_d = req_oor;
                    idx_d    = req_idx;
                    wdata_d  = writedata;
                    be_d     = byteenable;
                    wcnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (op_wr_q ? !write : !read) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_d  = S_IDLE;
                ack_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Read data is captured on the edge entering ACK so it is stable for the whole ACK cycle.
        if (enter_ack && !op_wr_d) begin
            readdata_d = op_oor_d ? OOR_DATA : mem[idx_d];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 4'd0;
            op_wr_q    <= 1'b0;
            op_oor_q   <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            readdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            op_wr_q    <= op_wr_d;
            op_oor_q   <= op_oor_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            readdata_q <= readdata_d;
        end
    end

    // Memory is deliberately left out of reset so contents survive a reset pulse.
    assign mem_we = sys_rst_n && ack_done && op_wr_q && !op_oor_q;

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign waitrequest = (state_q != S_ACK);
    assign readdata    = readdata_q;

`ifdef RESP_STATS_EN
    logic        op_both_q, op_both_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] err_count_q, err_count_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        op_both_d   = op_both_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (state_q == S_IDLE && (read || write)) begin
            op_both_d = read && write;
        end
        if (ack_done) begin
            if (op_wr_q) begin
                wr_count_d = sat_inc(wr_count_q);
            end else begin
                rd_count_d = sat_inc(rd_count_q);
            end
        end
        if ((ack_done && (op_oor_q || op_both_q)) || abort) begin
            err_count_d = sat_inc(err_count_q);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            op_both_q   <= 1'b0;
            rd_count_q  <= 16'h0;
            wr_count_q  <= 16'h0;
            err_count_q <= 16'h0;
        end else begin
            op_both_q   <= op_both_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`else
    assign rd_count  = 16'h0;
    assign wr_count  = 16'h0;
    assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_avalon_mm_responder.sv
// tb/tb_avalon_mm_responder.sv - self-checking bench for avalon_mm_responder (two configurations).
module tb_avalon_mm_responder;
    localparam logic [31:0] BASE_A = 32'h1000_0000;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] address   [2];
    logic        read      [2];
    logic        write     [2];
    logic [31:0] writedata [2];
    logic [3:0]  be        [2];
    logic [31:0] readdata  [2];
    logic        waitreq   [2];
    logic [15:0] rdc       [2];
    logic [15:0] wrc       [2];
    logic [15:0] erc       [2];

    int n_pass  = 0;
    int n_total = 0;
    int exp_rd  = 0;
    int exp_wr  = 0;
    int exp_err = 0;

    avalon_mm_responder #(.DEPTH(64), .BASE_ADDR(BASE_A), .WAIT_STATES(2), .OOR_DATA(32'hDEAD_BEEF)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .address(address[0]), .read(read[0]),
        .write(write[0]), .writedata(writedata[0]), .byteenable(be[0]), .readdata(readdata[0]),
        .waitrequest(waitreq[0]), .rd_count(rdc[0]), .wr_count(wrc[0]), .err_count(erc[0])
    );

    avalon_mm_responder #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0), .OOR_DATA(32'hDEAD_BEEF)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .address(address[1]), .read(read[1]),
        .write(write[1]), .writedata(writedata[1]), .byteenable(be[1]), .readdata(readdata[1]),
        .waitrequest(waitreq[1]), .rd_count(rdc[1]), .wr_count(wrc[1]), .err_count(erc[1])
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_counts(input int d, input string nm, input int er, input int ew, input int ee);
`ifdef RESP_STATS_EN
        chk({nm, " rd_count"}, 32'(rdc[d]), 32'(er));
        chk({nm, " wr_count"}, 32'(wrc[d]), 32'(ew));
        chk({nm, " err_count"}, 32'(erc[d]), 32'(ee));
`else
        chk({nm, " rd_count"}, 32'(rdc[d]), 32'(er & 0));
        chk({nm, " wr_count"}, 32'(wrc[d]), 32'(ew & 0));
        chk({nm, " err_count"}, 32'(erc[d]), 32'(ee & 0));
`endif
    endtask

    // Called at posedge+1; returns readdata seen in the ACK cycle and the number of cycles to ACK inclusive.
    task automatic access(input int d, input bit wr, input bit both, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] ben,
                          output logic [31:0] rd, output int lat);
        address[d]   = addr;
        writedata[d] = data;
        be[d]        = ben;
        write[d]     = wr | both;
        read[d]      = ~wr | both;
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (waitreq[d] && lat < 40);
        rd = readdata[d];
        @(posedge sys_clk);
        #1;
        read[d]  = 1'b0;
        write[d] = 1'b0;
    endtask

    function automatic bit is_oor(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >= 32'd256;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] mdl [64];
    logic [31:0] rd;
    int          lat;
    bit          went_low;

    initial begin
        tbl[0]  = '{1'b1, BASE_A + 32'd8,   32'hA5A5_1234, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, BASE_A + 32'd8,   32'h0,         4'hF, 32'hA5A5_1234};
        tbl[2]  = '{1'b0, BASE_A + 32'd11,  32'h0,         4'hF, 32'hA5A5_1234};
        tbl[3]  = '{1'b1, BASE_A + 32'd16,  32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[4]  = '{1'b1, BASE_A + 32'd16,  32'h0000_0000, 4'h5, 32'h0};
        tbl[5]  = '{1'b0, BASE_A + 32'd16,  32'h0,         4'hF, 32'hFF00_FF00};
        tbl[6]  = '{1'b0, BASE_A + 32'd256, 32'h0,         4'hF, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b0, BASE_A - 32'd4,   32'h0,         4'hF, 32'hDEAD_BEEF};
        tbl[8]  = '{1'b1, BASE_A + 32'd20,  32'h1122_3344, 4'hF, 32'h0};
        tbl[9]  = '{1'b1, BASE_A + 32'd20,  32'h9999_9999, 4'h0, 32'h0};
        tbl[10] = '{1'b0, BASE_A + 32'd20,  32'h0,         4'hF, 32'h1122_3344};
        tbl[11] = '{1'b1, BASE_A + 32'd44,  32'hCAFE_F00D, 4'hF, 32'h0};
        tbl[12] = '{1'b1, BASE_A + 32'd300, 32'h0000_0000, 4'hF, 32'h0};
        tbl[13] = '{1'b0, BASE_A + 32'd44,  32'h0,         4'hF, 32'hCAFE_F00D};
        tbl[14] = '{1'b1, BASE_A + 32'd252, 32'h0BAD_F00D, 4'hF, 32'h0};
        tbl[15] = '{1'b0, BASE_A + 32'd252, 32'h0,         4'hF, 32'h0BAD_F00D};

        for (int d = 0; d < 2; d++) begin
            address[d] = 32'h0; read[d] = 1'b0; write[d] = 1'b0;
            writedata[d] = 32'h0; be[d] = 4'h0;
        end

        // Reset held for three cycles
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset waitrequest A", 32'(waitreq[0]), 32'd1);
        chk("reset waitrequest B", 32'(waitreq[1]), 32'd1);
        chk("reset readdata A", readdata[0], 32'h0);
        chk_counts(0, "reset", 0, 0, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Table-driven accesses on the WAIT_STATES=2 instance
        foreach (tbl[i]) begin
            access(0, tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].data, tbl[i].ben, rd, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            if (tbl[i].wr) exp_wr++;
            else begin
                exp_rd++;
                chk($sformatf("vec%0d readdata", i), rd, tbl[i].exp);
            end
            if (is_oor(tbl[i].addr, BASE_A)) exp_err++;
        end
        chk_counts(0, "table", exp_rd, exp_wr, exp_err);
        repeat (2) @(negedge sys_clk);
        chk("readdata hold", readdata[0], 32'h0BAD_F00D);
        @(posedge sys_clk);
        #1;

        // Read dropped during WAIT
        address[0] = BASE_A + 32'd8; read[0] = 1'b1;
        @(posedge sys_clk);
        #1;
        read[0] = 1'b0;
        went_low = 1'b0;
        repeat (6) begin
            @(negedge sys_clk);
            if (!waitreq[0]) went_low = 1'b1;
        end
        chk("read abort no ack", 32'(went_low), 32'd0);
        exp_err++;
        @(posedge sys_clk);
        #1;

        // Write dropped during WAIT must not commit
        address[0] = BASE_A + 32'd8; writedata[0] = 32'h0; be[0] = 4'hF; write[0] = 1'b1;
        @(posedge sys_clk);
        #1;
        write[0] = 1'b0;
        went_low = 1'b0;
        repeat (6) begin
            @(negedge sys_clk);
            if (!waitreq[0]) went_low = 1'b1;
        end
        chk("write abort no ack", 32'(went_low), 32'd0);
        exp_err++;
        @(posedge sys_clk);
        #1;
        access(0, 1'b0, 1'b0, BASE_A + 32'd8, 32'h0, 4'hF, rd, lat);
        exp_rd++;
        chk("write abort no commit", rd, 32'hA5A5_1234);

        // Read and write together: write wins, error counted
        access(0, 1'b1, 1'b1, BASE_A + 32'd24, 32'h5A5A_5A5A, 4'hF, rd, lat);
        exp_wr++; exp_err++;
        chk("rw both latency", 32'(lat), 32'd4);
        access(0, 1'b0, 1'b0, BASE_A + 32'd24, 32'h0, 4'hF, rd, lat);
        exp_rd++;
        chk("rw both write applied", rd, 32'h5A5A_5A5A);
        chk_counts(0, "after aborts", exp_rd, exp_wr, exp_err);

        // Reset in the middle of WAIT
        address[0] = BASE_A + 32'd8; writedata[0] = 32'h0; be[0] = 4'hF; write[0] = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        write[0]  = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("mid reset waitrequest", 32'(waitreq[0]), 32'd1);
        chk("mid reset readdata", readdata[0], 32'h0);
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        chk_counts(0, "mid reset", 0, 0, 0);
        @(posedge sys_clk);
        #1;
        access(0, 1'b0, 1'b0, BASE_A + 32'd8, 32'h0, 4'hF, rd, lat);
        chk("memory retained after reset", rd, 32'hA5A5_1234);

        // Random back-to-back traffic on the WAIT_STATES=0 instance against a word-array model
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        for (int n = 0; n < 100; n++) begin
            bit          wr;
            bit          oor;
            int          w;
            logic [31:0] addr;
            logic [31:0] data;
            logic [3:0]  ben;
            w    = $urandom_range(0, 7);
            data = $urandom;
            if (n < 8) begin
                wr = 1'b1; w = n; ben = 4'hF; oor = 1'b0;
            end else begin
                wr  = 1'($urandom_range(0, 1));
                ben = 4'($urandom_range(0, 15));
                oor = ($urandom_range(0, 7) == 0);
            end
            addr = (oor ? 32'd256 : 32'd0) + 32'(w * 4) + 32'($urandom_range(0, 3));
            access(1, wr, 1'b0, addr, data, ben, rd, lat);
            chk($sformatf("rand%0d latency", n), 32'(lat), 32'd2);
            if (oor) exp_err++;
            if (wr) begin
                exp_wr++;
                if (!oor) begin
                    for (int b = 0; b < 4; b++)
                        if (ben[b]) mdl[w][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                exp_rd++;
                chk($sformatf("rand%0d readdata", n), rd, oor ? 32'hDEAD_BEEF : mdl[w]);
            end
        end
`ifdef RESP_STATS_EN
        chk("random rd+wr total", 32'(rdc[1]) + 32'(wrc[1]), 32'd100);
`endif
        chk_counts(1, "random", exp_rd, exp_wr, exp_err);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
